// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor elevator controller core.
// Latches floor requests, serves them in SCAN (sweep) order, holds the door
// open for a programmable number of ticks. All timing derives from an
// internal tick prescaler; all outputs are registered.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int MOVE_TICKS = 1,
    parameter int DOOR_TICKS = 3,
    localparam int FW        = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_in,
    output logic [FW-1:0]         floor_idx,
    output logic [NUM_FLOORS-1:0] floor_oh,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam int TW   = $clog2(TICK_DIV);
    localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int PW   = $clog2(MAXT + 1);

    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    logic [1:0]            state_r;
    logic [TW-1:0]         tick_cnt_r;
    logic [PW-1:0]         phase_cnt_r;

    logic [1:0]            state_s;
    logic [FW-1:0]         floor_s;
    logic                  dir_s;
    logic [TW-1:0]         tick_cnt_s;
    logic [PW-1:0]         phase_cnt_s;
    logic [NUM_FLOORS-1:0] clr_s;
    logic [NUM_FLOORS-1:0] mask_s;
    logic [NUM_FLOORS-1:0] pending_s;
    logic [FW-1:0]         step_floor_s;
    logic                  restart_s;
    logic                  tick_s;
    logic                  above_s;
    logic                  below_s;
    logic                  here_s;

    // One-hot code of a floor index.
    function automatic logic [NUM_FLOORS-1:0] to_onehot(input logic [FW-1:0] f);
        to_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    // Any request strictly above floor f.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) begin
                r = r | req[i];
            end else begin
                r = r;
            end
        end
        any_above = r;
    endfunction

    // Any request strictly below floor f.
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) begin
                r = r | req[i];
            end else begin
                r = r;
            end
        end
        any_below = r;
    endfunction

    assign tick_s  = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign above_s = any_above(pending, floor_idx);
    assign below_s = any_below(pending, floor_idx);
    assign here_s  = pending[floor_idx];

    // Neighbouring floor in the sweep direction, clamped to the shaft.
    always_comb begin
        step_floor_s = floor_idx;
        if (dir_up) begin
            if (floor_idx == TOP_FLOOR) begin
                step_floor_s = floor_idx;
            end else begin
                step_floor_s = floor_idx + FW'(1);
            end
        end else begin
            if (floor_idx == FW'(0)) begin
                step_floor_s = floor_idx;
            end else begin
                step_floor_s = floor_idx - FW'(1);
            end
        end
    end

    // Next-state decision: SCAN scheduling, floor stepping and door timing.
    always_comb begin
        state_s   = state_r;
        floor_s   = floor_idx;
        dir_s     = dir_up;
        clr_s     = '0;
        mask_s    = '0;
        restart_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (here_s) begin
                    state_s = ST_DOOR;
                    clr_s   = to_onehot(floor_idx);
                    mask_s  = to_onehot(floor_idx);
                end else if (dir_up && above_s) begin
                    state_s = ST_MOVE;
                end else if (below_s) begin
                    state_s = ST_MOVE;
                    dir_s   = 1'b0;
                end else if (above_s) begin
                    state_s = ST_MOVE;
                    dir_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (tick_s && (phase_cnt_r == PW'(MOVE_TICKS - 1))) begin
                    // Arrival: decide on the floor just reached.
                    floor_s   = step_floor_s;
                    restart_s = 1'b1;
                    if (pending[step_floor_s]) begin
                        state_s = ST_DOOR;
                        clr_s   = to_onehot(step_floor_s);
                        mask_s  = to_onehot(step_floor_s);
                    end else if (dir_up ? any_above(pending, step_floor_s)
                                        : any_below(pending, step_floor_s)) begin
                        state_s = ST_MOVE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_MOVE;
                end
            end
            ST_DOOR: begin
                // Calls for the open floor are absorbed, not latched.
                mask_s = to_onehot(floor_idx);
                if (tick_s && (phase_cnt_r == PW'(DOOR_TICKS - 1))) begin
                    state_s   = ST_IDLE;
                    restart_s = 1'b1;
                end else begin
                    state_s = ST_DOOR;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                restart_s = 1'b1;
            end
        endcase
    end

    // Prescaler and phase tick counter; restarted on every phase change.
    always_comb begin
        tick_cnt_s  = tick_cnt_r;
        phase_cnt_s = phase_cnt_r;
        if (restart_s || (state_r == ST_IDLE) || (state_s != state_r)) begin
            tick_cnt_s  = '0;
            phase_cnt_s = '0;
        end else if (tick_s) begin
            tick_cnt_s  = '0;
            phase_cnt_s = phase_cnt_r + PW'(1);
        end else begin
            tick_cnt_s  = tick_cnt_r + TW'(1);
            phase_cnt_s = phase_cnt_r;
        end
    end

    // Sticky request latch with clear-on-service and door-floor masking.
    always_comb begin
        pending_s = (pending & ~clr_s) | (req_in & ~mask_s);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            phase_cnt_r <= '0;
            floor_idx   <= '0;
            floor_oh    <= {{(NUM_FLOORS-1){1'b0}}, 1'b1};
            dir_up      <= 1'b1;
            moving      <= 1'b0;
            door_open   <= 1'b0;
            pending     <= '0;
        end else begin
            state_r     <= state_s;
            tick_cnt_r  <= tick_cnt_s;
            phase_cnt_r <= phase_cnt_s;
            floor_idx   <= floor_s;
            floor_oh    <= to_onehot(floor_s);
            dir_up      <= dir_s;
            moving      <= (state_s == ST_MOVE);
            door_open   <= (state_s == ST_DOOR);
            pending     <= pending_s;
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with NUM_FLOORS=4, TICK_DIV=4,
// MOVE_TICKS=1, DOOR_TICKS=2 (one floor step = 4 cycles, door = 8 cycles).
// Status vector = {floor_idx, floor_oh, dir_up, moving, door_open, pending}.
module tb_elevator_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [1:0] floor_idx;
    logic [3:0] floor_oh;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [3:0] pending;

    logic [12:0] status_s;
    logic [12:0] exp_s;
    int tests_run;
    int tests_failed;

    assign status_s = {floor_idx, floor_oh, dir_up, moving, door_open, pending};

    elevator_scan_ctrl #(
        .NUM_FLOORS(4),
        .TICK_DIV  (4),
        .MOVE_TICKS(1),
        .DOOR_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .floor_idx(floor_idx),
        .floor_oh (floor_oh),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = 4'b0000;
        step(2);
        exp_s = {2'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL reset_state: got %b exp %b", status_s, exp_s); end
        rst_n = 1'b1;
        step(2);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL reset_idle: got %b exp %b", status_s, exp_s); end
    endtask

    task automatic test_sweep_up();
        req_in = 4'b1000; step(1); req_in = 4'b0000;
        exp_s = {2'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_latch: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_move: got %b exp %b", status_s, exp_s); end
        step(3);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_before_f1: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd1, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_f1: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd2, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_f2: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd3, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_f3_door: got %b exp %b", status_s, exp_s); end
        step(7);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_door_hold: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd3, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_door_close: got %b exp %b", status_s, exp_s); end
        step(2);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL up_stay_idle: got %b exp %b", status_s, exp_s); end
    endtask

    task automatic test_sweep_down();
        req_in = 4'b0101; step(1); req_in = 4'b0000;
        exp_s = {2'd3, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0101}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_latch: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd3, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0101}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_reverse: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd2, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_f2_door: got %b exp %b", status_s, exp_s); end
        step(8);
        exp_s = {2'd2, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_f2_idle: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd2, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_resume: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_pass_f1: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_f0_door: got %b exp %b", status_s, exp_s); end
        step(8);
        exp_s = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dn_f0_idle: got %b exp %b", status_s, exp_s); end
    endtask

    task automatic test_here();
        req_in = 4'b0001; step(1); req_in = 4'b0000;
        exp_s = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL here_latch: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL here_door: got %b exp %b", status_s, exp_s); end
        step(7);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL here_door_hold: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL here_close: got %b exp %b", status_s, exp_s); end
    endtask

    task automatic test_pass_by();
        req_in = 4'b1000; step(1); req_in = 4'b0000;
        step(1);
        exp_s = {2'd0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL pb_move: got %b exp %b", status_s, exp_s); end
        step(2);
        req_in = 4'b0100; step(1); req_in = 4'b0000;
        exp_s = {2'd0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1100}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL pb_latch: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd1, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b1100}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL pb_f1: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd2, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL pb_f2_door: got %b exp %b", status_s, exp_s); end
        step(9);
        exp_s = {2'd2, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL pb_continue: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd3, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL pb_f3_door: got %b exp %b", status_s, exp_s); end
        step(8);
    endtask

    task automatic test_reverse();
        req_in = 4'b0100; step(1); req_in = 4'b0000;
        step(13);
        exp_s = {2'd2, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_at_f2: got %b exp %b", status_s, exp_s); end
        req_in = 4'b1000; step(1); req_in = 4'b0000;
        step(1);
        exp_s = {2'd2, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_up: got %b exp %b", status_s, exp_s); end
        step(2);
        req_in = 4'b0001; step(1); req_in = 4'b0000;
        exp_s = {2'd2, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_latch: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd3, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_f3_first: got %b exp %b", status_s, exp_s); end
        step(9);
        exp_s = {2'd3, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_turn: got %b exp %b", status_s, exp_s); end
        step(8);
        exp_s = {2'd1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0001}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_f1: got %b exp %b", status_s, exp_s); end
        step(4);
        exp_s = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rv_f0_door: got %b exp %b", status_s, exp_s); end
        step(8);
    endtask

    task automatic test_reset_mid_move();
        req_in = 4'b0100; step(1); req_in = 4'b0000;
        step(5);
        exp_s = {2'd1, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0100}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rm_f1: got %b exp %b", status_s, exp_s); end
        step(2);
        rst_n = 1'b0;
        #2;
        exp_s = {2'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rm_async: got %b exp %b", status_s, exp_s); end
        step(1);
        rst_n = 1'b1;
        step(2);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL rm_after: got %b exp %b", status_s, exp_s); end
    endtask

    task automatic test_door_mask();
        req_in = 4'b0010; step(1); req_in = 4'b0000;
        step(5);
        exp_s = {2'd1, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dm_door: got %b exp %b", status_s, exp_s); end
        step(3);
        req_in = 4'b0010; step(1); req_in = 4'b0000;
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dm_absorb: got %b exp %b", status_s, exp_s); end
        step(3);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dm_hold: got %b exp %b", status_s, exp_s); end
        step(1);
        exp_s = {2'd1, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000}; tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dm_close: got %b exp %b", status_s, exp_s); end
        step(2);
        tests_run++;
        if (status_s !== exp_s) begin tests_failed++; $display("FAIL dm_no_reopen: got %b exp %b", status_s, exp_s); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_in       = 4'b0000;
        test_reset();
        test_sweep_up();
        test_sweep_down();
        test_here();
        test_pass_by();
        test_reverse();
        test_reset_mid_move();
        test_door_mask();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
